// File: rtl/mgpu_mtrx_pkg.sv
// Shared definitions for the matrix datapath sequencer: select codes,
// matrix geometry and the sequencer state encoding.
package mgpu_mtrx_pkg;

  localparam int unsigned MTRX_W  = 336;
  localparam int unsigned ELEM_W  = 21;
  localparam int unsigned NUM_STG = 6;

  localparam logic [2:0] MSEL_NONE  = 3'd0;
  localparam logic [2:0] MSEL_INPUT = 3'd1;
  localparam logic [2:0] MSEL_ROTX  = 3'd2;
  localparam logic [2:0] MSEL_ROTY  = 3'd3;
  localparam logic [2:0] MSEL_ROTZ  = 3'd4;
  localparam logic [2:0] MSEL_SHIFT = 3'd5;
  localparam logic [2:0] MSEL_PROJ  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SEND,
    DONE
  } mtrx_state_e;

  // Stage index (bit position in stage_en) to mux select code.
  function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
    logic [2:0] sel;
    case (idx)
      3'd0:    sel = MSEL_INPUT;
      3'd1:    sel = MSEL_ROTX;
      3'd2:    sel = MSEL_ROTY;
      3'd3:    sel = MSEL_ROTZ;
      3'd4:    sel = MSEL_SHIFT;
      3'd5:    sel = MSEL_PROJ;
      default: sel = MSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mtrx_next_stage.sv
// Combinational finder: lowest set mask bit at or above from_idx.
module mtrx_next_stage
  import mgpu_mtrx_pkg::*;
(
  input  logic [5:0] mask,
  input  logic [2:0] from_idx,
  output logic [2:0] nxt_idx,
  output logic       none_left
);

  logic found;

  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_STG; i++) begin
      if (!found && (i >= 32'(from_idx)) && mask[i]) begin
        nxt_idx = 3'(i);
        found   = 1'b1;
      end
    end
    none_left = !found;
  end

endmodule

// File: rtl/mtrx_seq_ctrl.sv
// Per-frame matrix sequencer: settle delay after frame_start, then issue the
// enabled matrices one at a time over a valid/ready handshake.
module mtrx_seq_ctrl
  import mgpu_mtrx_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [5:0] stage_en,
  input  logic       mtrx_ready,
  input  logic       clr_overrun,
  output logic [2:0] mtrx_sel,
  output logic       mtrx_valid,
  output logic       mtrx_last,
  output logic       frame_done,
  output logic       busy,
  output logic       overrun
);

  mtrx_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  snap_q, snap_d;
  logic [2:0]  cur_q, cur_d;

  logic [2:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [2:0]  pick_from, pick_idx;
  logic        pick_none;
  logic [2:0]  tail_from, tail_idx;
  logic        tail_none;

  // One finder picks the first/next stage, the other looks above that pick
  // so mtrx_last can be registered together with mtrx_sel.
  assign pick_from = (state_q == SEND) ? 3'(cur_q + 3'd1) : '0;
  assign tail_from = 3'(cur_d + 3'd1);

  mtrx_next_stage u_pick (
    .mask      (snap_q),
    .from_idx  (pick_from),
    .nxt_idx   (pick_idx),
    .none_left (pick_none)
  );

  mtrx_next_stage u_tail (
    .mask      (snap_d),
    .from_idx  (tail_from),
    .nxt_idx   (tail_idx),
    .none_left (tail_none)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      cur_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      cur_q     <= cur_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE, DONE: begin
        if (frame_start) begin
          state_d = SETTLE;
          snap_d  = stage_en;
          cnt_d   = 8'(SETTLE_CYC - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (pick_none) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            cur_d   = pick_idx;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SEND: begin
        if (mtrx_ready) begin
          if (pick_none) begin
            state_d = DONE;
          end else begin
            cur_d = pick_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    valid_d   = (state_d == SEND);
    sel_d     = valid_d ? idx_to_sel(cur_d) : MSEL_NONE;
    last_d    = valid_d && tail_none;
    done_d    = (state_d == DONE);
    busy_d    = (state_d == SETTLE) || (state_d == SEND);
    overrun_d = overrun_q;
    if (frame_start && ((state_q == SETTLE) || (state_q == SEND))) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  assign mtrx_sel   = sel_q;
  assign mtrx_valid = valid_q;
  assign mtrx_last  = last_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

  logic unused_tail;
  assign unused_tail = ^tail_idx;

endmodule
